// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: machine width, instruction size, fetch FSM states
// and the queue entry layout used by if_fetch_queue and fetchq_fifo.
package pipeline_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] next_pc;
  } fetchq_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// Circular instruction queue: storage, read/write pointers and occupancy count.
// Clear empties the queue; a pop on an empty queue is ignored.
module fetchq_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  fetchq_entry_t          i_entry,
  input  logic                   i_pop,
  output fetchq_entry_t          o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetchq_entry_t   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push_s, pop_s;

  assign pop_s  = i_pop && (count_q != {CW{1'b0}});
  assign push_s = i_push && ((count_q != CW'(DEPTH)) || pop_s);

  // Occupancy update: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      count_q <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge i_clk) begin
    if (push_s && i_rst_n && !i_clr) mem_q[wr_ptr_q] <= i_entry;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: single-outstanding memory request FSM, fetch PC and
// branch redirect feeding a fetchq_fifo. Optional perf counters: FETCHQ_PERF_EN.
module if_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_instr,
`ifdef FETCHQ_PERF_EN
  output logic [15:0] o_perf_flush_cnt,
  output logic [15:0] o_perf_bubble_cnt,
`endif
  output logic [31:0] o_next_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] target_s, pc_inc_s;
  logic            req_s, push_s, room_s;
  logic [CW-1:0]   count_s;
  fetchq_entry_t   head_s, entry_s;

  assign target_s = i_branch_pc & 32'hFFFF_FFFC;
  assign pc_inc_s = pc_q + XLEN'(INSTR_BYTES);
  assign room_s   = count_s < CW'(DEPTH);
  assign entry_s  = '{instr: i_imem_data, next_pc: pc_inc_s};

  // Fetch FSM: a new request is offered in ISSUE and may be acked in that same cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_s   = 1'b0;
    push_s  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (i_branch_taken) begin
          pc_d = target_s;
        end else if (room_s) begin
          req_s  = 1'b1;
          addr_d = pc_q;
          if (i_imem_ack) begin
            push_s = 1'b1;
            pc_d   = pc_inc_s;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        req_s = 1'b1;
        if (i_branch_taken) begin
          pc_d    = target_s;
          state_d = i_imem_ack ? ST_ISSUE : ST_DISCARD;
        end else if (i_imem_ack) begin
          push_s  = 1'b1;
          pc_d    = pc_inc_s;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        // Stale request still owns the bus; only its completion frees the FSM
        req_s = 1'b1;
        if (i_branch_taken) pc_d = target_s;
        else                pc_d = pc_q;
        if (i_imem_ack) state_d = ST_ISSUE;
        else            state_d = ST_DISCARD;
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  // FSM, fetch PC and held request address
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_ISSUE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_branch_taken),
    .i_push  (push_s),
    .i_entry (entry_s),
    .i_pop   (o_valid && i_id_ready),
    .o_head  (head_s),
    .o_count (count_s)
  );

  assign o_imem_req  = req_s && i_rst_n;
  assign o_imem_addr = (state_q == ST_ISSUE) ? pc_q : addr_q;
  assign o_valid     = (count_s != {CW{1'b0}});
  assign o_instr     = o_valid ? head_s.instr   : 32'h0000_0000;
  assign o_next_pc   = o_valid ? head_s.next_pc : 32'h0000_0000;

`ifdef FETCHQ_PERF_EN
  logic [15:0] flush_cnt_q, bubble_cnt_q;

  // Saturating flush and bubble counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      flush_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      if (i_branch_taken && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'h0001;
      if (!o_valid && i_id_ready && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_q <= bubble_cnt_q + 16'h0001;
    end
  end

  assign o_perf_flush_cnt  = flush_cnt_q;
  assign o_perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic,
// checked each cycle against a queue-based behavioural model.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        br;
  logic [31:0] br_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack;
  logic [31:0] imem_data;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] next_pc;
`ifdef FETCHQ_PERF_EN
  logic [15:0] perf_flush;
  logic [15:0] perf_bubble;
`endif

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_branch_taken (br),
    .i_branch_pc    (br_pc),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_ack     (ack),
    .i_imem_data    (imem_data),
    .o_valid        (valid),
    .i_id_ready     (ready),
    .o_instr        (instr),
`ifdef FETCHQ_PERF_EN
    .o_perf_flush_cnt  (perf_flush),
    .o_perf_bubble_cnt (perf_bubble),
`endif
    .o_next_pc      (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: queue of {instr, pc+4}, one outstanding-request flag
  logic [31:0] m_instr_q [$];
  logic [31:0] m_npc_q   [$];
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_out;
  bit          m_stale;
  int          m_flushes;
  int          m_bubbles;

  function automatic void model_reset();
    m_instr_q.delete();
    m_npc_q.delete();
    m_pc       = RESET_PC;
    m_req_addr = RESET_PC;
    m_out      = 1'b0;
    m_stale    = 1'b0;
    m_flushes  = 0;
    m_bubbles  = 0;
  endfunction

  // One cycle: drive inputs, compare outputs, clock, advance model
  task automatic step(input bit r, input bit b, input logic [31:0] bpc,
                      input bit a, input logic [31:0] d, input bit rd);
    bit          e_req, e_valid, acked, popped;
    logic [31:0] e_addr, e_instr, e_npc;
    @(negedge clk);
    rst_n = r; br = b; br_pc = bpc; ack = a; imem_data = d; ready = rd;
    #1;
    e_valid = (m_instr_q.size() > 0);
    e_req   = r && (m_out || (!b && m_instr_q.size() < DEPTH));
    e_addr  = m_out ? m_req_addr : m_pc;
    e_instr = e_valid ? m_instr_q[0] : 32'h0;
    e_npc   = e_valid ? m_npc_q[0]   : 32'h0;
    check_eq("imem_req",  {31'h0, imem_req}, {31'h0, e_req});
    check_eq("imem_addr", imem_addr, e_addr);
    check_eq("valid",     {31'h0, valid}, {31'h0, e_valid});
    check_eq("instr",     instr, e_instr);
    check_eq("next_pc",   next_pc, e_npc);
`ifdef FETCHQ_PERF_EN
    check_eq("perf_flush",  {16'h0, perf_flush},  m_flushes > 65535 ? 32'hFFFF : 32'(m_flushes));
    check_eq("perf_bubble", {16'h0, perf_bubble}, m_bubbles > 65535 ? 32'hFFFF : 32'(m_bubbles));
`endif
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      acked  = e_req && a;
      popped = e_valid && rd;
      if (b) m_flushes++;
      if (!e_valid && rd) m_bubbles++;
      if (b) begin
        m_instr_q.delete();
        m_npc_q.delete();
        m_pc = bpc & ~32'h3;
        if (m_out && !acked) m_stale = 1'b1;
        else begin m_out = 1'b0; m_stale = 1'b0; end
      end else begin
        if (popped) begin
          void'(m_instr_q.pop_front());
          void'(m_npc_q.pop_front());
        end
        if (acked) begin
          if (!m_stale) begin
            m_instr_q.push_back(d);
            m_npc_q.push_back(m_pc + 32'd4);
            m_pc = m_pc + 32'd4;
          end
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else if (e_req && !m_out) begin
          m_out      = 1'b1;
          m_req_addr = m_pc;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; br = 1'b0; br_pc = 32'h0; ack = 1'b0; imem_data = 32'h0; ready = 1'b0;
    @(posedge clk);
    model_reset();
    do_reset();

    // Streaming: ack with request, ID always ready
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0000 + i, 1'b1);

    // Back-pressure fills the queue, then drain
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 32'hB000_0000 + i, 1'b0);
    #1 check_eq("full_no_req", {31'h0, imem_req}, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Pending request at 0x10, redirect to 0x103 while waiting
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 32'hC000_0000 + i, 1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_0010, 1'b1);
    #1 check_eq("redirect_addr", imem_addr, 32'h0000_0100);
    step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0100, 1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1);

    // Flush coincident with ack at 0x20, target 0x40
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 32'hE000_0000 + i, 1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'hDEAD_0020, 1'b0);
    #1 check_eq("flush_empty", {31'h0, valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0,         1'b1, 32'hE000_0040, 1'b1);
    step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1);

    // Reset while a request waits; late ack must be ignored
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0001, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 32'hF000_0000 + i, 1'b1);

`ifdef FETCHQ_PERF_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check_eq("three_flushes", {16'h0, perf_flush}, 32'd3);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) != 0),
           ($urandom_range(19) == 0),
           $urandom,
           ($urandom_range(1) == 1),
           $urandom,
           ($urandom_range(9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
